// File: rtl/riscv_pkg.sv
// Shared RV32 decode types and commit-trace record definitions.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [5:0] {
      OP_NOP, LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU,
      SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      FENCE, ECALL, EBREAK
   } operation_e;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      REG   = 2'd1,
      LOAD  = 2'd2,
      STORE = 2'd3
   } trace_kind_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      trace_kind_e       kind;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   instr;
      logic [4:0]        rd;
      logic [XLEN-1:0]   data;
      logic [XLEN-1:0]   addr;
      logic [1:0]        size;
   } trace_entry_t;

   // Store data as it appears on the bus after byte/half-word masking.
   function automatic logic [XLEN-1:0] store_data(input operation_e op,
                                                  input logic [XLEN-1:0] wdata);
      case (op)
         SB:      store_data = XLEN'(wdata[7:0]);
         SH:      store_data = XLEN'(wdata[15:0]);
         default: store_data = wdata;
      endcase
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with a registered head entry and registered status flags.
module trace_fifo #(
   parameter int unsigned DEPTH   = 8,
   parameter type         entry_t = logic [31:0]
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 head,
   output logic                   valid,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
   logic [CNT_W-1:0]   count_q, count_d;
   entry_t             head_q, head_d;
   logic               valid_q, full_q, empty_q;
   logic               do_push, do_pop;

   assign do_pop  = pop && !empty_q;
   assign do_push = push && (!full_q || do_pop);
   assign rd_nxt  = rd_ptr_q + PTR_W'(1);

   // Next head: the following stored entry, the incoming entry, or cleared when drained.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_nxt;
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
      if (do_pop) begin
         if (count_q > CNT_W'(1)) head_d = mem[rd_nxt];
         else if (do_push)        head_d = push_data;
         else                     head_d = '0;
      end else if (do_push && count_q == '0) begin
         head_d = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
         full_q   <= (count_d == CNT_W'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   assign head  = head_q;
   assign valid = valid_q;
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: classifies committed instructions into records and buffers them for a sink.
// Optional TRACE_DROP_CNT_EN adds a saturating 16-bit dropped-record counter output.
module commit_trace_buffer
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   update_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic [XLEN-1:0]        instr_i,
   input  logic [4:0]             reg_addr_i,
   input  logic [XLEN-1:0]        reg_data_i,
   input  logic [XLEN-1:0]        mem_read_addr_i,
   input  logic [XLEN-1:0]        mem_write_addr_i,
   input  logic [XLEN-1:0]        mem_write_data_i,
   input  logic                   mem_read_enable_i,
   input  logic                   mem_write_enable_i,
   input  logic                   rf_write_enable_i,
   input  operation_e             operation_i,
   output logic                   trace_valid_o,
   input  logic                   trace_ready_i,
   output trace_kind_e            trace_kind_o,
   output logic [XLEN-1:0]        trace_pc_o,
   output logic [XLEN-1:0]        trace_instr_o,
   output logic [4:0]             trace_rd_o,
   output logic [XLEN-1:0]        trace_data_o,
   output logic [XLEN-1:0]        trace_addr_o,
   output logic [1:0]             trace_size_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o,
`ifdef TRACE_DROP_CNT_EN
   output logic [15:0]            drop_cnt_o,
`endif
   output logic                   overflow_o
);

   trace_entry_t entry_c, head;
   logic         capture_c, pop_c, push_ok_c;

   // Record classification in priority order: store, load, plain retire.
   always_comb begin
      entry_c       = '0;
      capture_c     = 1'b0;
      entry_c.pc    = pc_i;
      entry_c.instr = instr_i;
      if (update_i && pc_i != '0) begin
         if (mem_write_enable_i) begin
            entry_c.kind = STORE;
            entry_c.addr = mem_write_addr_i;
            entry_c.data = store_data(operation_i, mem_write_data_i);
            case (operation_i)
               SB: begin capture_c = 1'b1; entry_c.size = SIZE_BYTE; end
               SH: begin capture_c = 1'b1; entry_c.size = SIZE_HALF; end
               SW: begin capture_c = 1'b1; entry_c.size = SIZE_WORD; end
               default: capture_c = 1'b0;
            endcase
         end else if (mem_read_enable_i) begin
            if (reg_addr_i != '0) begin
               capture_c    = 1'b1;
               entry_c.kind = LOAD;
               entry_c.rd   = reg_addr_i;
               entry_c.data = reg_data_i;
               entry_c.addr = mem_read_addr_i;
            end
         end else begin
            capture_c = 1'b1;
            if (reg_addr_i != '0 && rf_write_enable_i) begin
               entry_c.kind = REG;
               entry_c.rd   = reg_addr_i;
               entry_c.data = reg_data_i;
            end
         end
      end
   end

   // A full FIFO still accepts a record when the head leaves in the same cycle.
   assign pop_c     = trace_valid_o && trace_ready_i;
   assign push_ok_c = !full_o || pop_c;

   trace_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (trace_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (capture_c && push_ok_c),
      .push_data (entry_c),
      .pop       (pop_c),
      .head      (head),
      .valid     (trace_valid_o),
      .full      (full_o),
      .empty     (empty_o),
      .count     (count_o)
   );

   assign trace_kind_o  = head.kind;
   assign trace_pc_o    = head.pc;
   assign trace_instr_o = head.instr;
   assign trace_rd_o    = head.rd;
   assign trace_data_o  = head.data;
   assign trace_addr_o  = head.addr;
   assign trace_size_o  = head.size;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) overflow_o <= 1'b0;
      else       overflow_o <= capture_c && !push_ok_c;
   end

`ifdef TRACE_DROP_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt_o <= '0;
      end else if (capture_c && !push_ok_c && drop_cnt_o != 16'hFFFF) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable retire-trace capture stage sitting directly downstream of `core_model`. Each cycle `update` is high, it classifies the retired instruction into a commit-log record: no-writeback, register write, load or store. Records are buffered in a DEPTH-entry FIFO and drained to a trace sink (logger, UART formatter) over a valid/ready handshake. It replaces simulation-only `$display` logging with a hardware path that yields the same record set.

## Interface
- DEPTH, 8, FIFO entries; power of two, minimum 2
- clk  in  1  core clock
- rstn  in  1  reset; one clock, reset is asynchronous and active-low
- update_i  in  1  retire strobe from core (`update_o`)
- pc_i  in  XLEN  retired PC
- instr_i  in  XLEN  retired instruction word
- reg_addr_i  in  5  destination register
- reg_data_i  in  XLEN  writeback data
- mem_read_addr_i  in  XLEN  load address
- mem_write_addr_i  in  XLEN  store address
- mem_write_data_i  in  XLEN  store data
- mem_read_enable_i  in  1  load retired
- mem_write_enable_i  in  1  store retired
- rf_write_enable_i  in  1  register file written
- operation_i  in  operation_e  decoded operation
- trace_valid_o  out  1  record available
- trace_ready_i  in  1  sink accepts record
- trace_kind_o  out  trace_kind_e  NONE / REG / LOAD / STORE
- trace_pc_o, trace_instr_o  out  XLEN  record PC / instruction
- trace_rd_o  out  5  rd (REG/LOAD); 0 otherwise
- trace_data_o  out  XLEN  reg data (REG/LOAD) or masked store data (STORE)
- trace_addr_o  out  XLEN  memory address (LOAD/STORE); 0 otherwise
- trace_size_o  out  2  store size: 0 byte, 1 half, 2 word; 0 otherwise
- count_o  out  $clog2(DEPTH)+1  occupancy
- full_o, empty_o  out  1  FIFO status
- overflow_o  out  1  one-cycle pulse when a record is dropped

## Operation
- Capture condition: `update_i` && `pc_i != 0`.
- Classification, in priority order:
  - `mem_write_enable_i` && operation in {SW, SH, SB} → STORE. Size is set from the operation. Data is `mem_write_data_i` zero-extended from bits [7:0] (SB) or [15:0] (SH).
  - `mem_write_enable_i` with any other operation → not captured.
  - `mem_read_enable_i` && rd != 0 → LOAD with rd, reg_data, mem_read_addr.
  - `mem_read_enable_i` && rd == 0 → not captured.
  - rd == 0 or !`rf_write_enable_i` → NONE.
  - Otherwise → REG.
- Push when capture is qualified and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise drop the record and pulse `overflow_o`. The FIFO contents are unchanged.
- Pop on `trace_valid_o && trace_ready_i`.
- `trace_*` outputs present the head entry and are held stable while valid && !ready.
- Pointers wrap modulo DEPTH. `count_o` is tracked explicitly; `full_o = (count_o == DEPTH)`.

## Timing
- Reset: all `trace_*` = 0, `trace_valid_o` = 0, `count_o` = 0, `empty_o` = 1, `full_o` = 0, `overflow_o` = 0, pointers = 0.
- Capture-to-valid latency is 1 cycle: a record pushed at edge N is on the outputs after edge N, with `trace_valid_o` high.
- Throughput is one push and one pop per cycle. Simultaneous push and pop leaves `count_o` unchanged.
- Simultaneous push and pop on an empty FIFO: no bypass. The pop is ignored because valid is low, and the push is stored.
- Reset asserted mid-stream flushes all entries asynchronously. A record being captured in that cycle is lost.

## Configuration
- `TRACE_DROP_CNT_EN` defined:
  - Adds output `drop_cnt_o` (16 bits).
  - Increments on every `overflow_o` pulse and saturates at 0xFFFF.
  - Reset value 0.
- Not defined: the port is absent and overflow is reported only by `overflow_o` pulses.

## Structure
- In `riscv_pkg`:
  - `trace_kind_e` (2-bit enum: NONE=0, REG=1, LOAD=2, STORE=3).
  - `trace_entry_t` packed struct: kind, pc, instr, rd, data, addr, size.
- Sub-module `trace_fifo`: generic synchronous FIFO parameterised on DEPTH and entry type, with push/pop/full/empty/count.
- The top level holds the classification logic and the overflow/drop logic.

## Test plan
- Reset, then one REG retire (pc=0x80000004, rd=5, data=0x12345678, rf_we=1) → next cycle valid=1, kind=REG, rd=5, data=0x12345678, count=1.
- SH retire with mem_write_data=0xDEADBEEF, addr=0x80001000 → kind=STORE, size=1, data=0x0000BEEF, addr=0x80001000.
- Load with rd=0, and a retire with pc=0 → nothing captured, count stays 0, no overflow.
- ready=0, 9 consecutive REG retires with DEPTH=8 → full=1 after the 8th, overflow pulses once on the 9th; with `TRACE_DROP_CNT_EN` defined, drop_cnt=1.
- Full FIFO with push and pop in the same cycle → count stays 8, no overflow, entries popped in push order.
- Assert rstn=0 while count=5 → outputs return to reset values immediately, without waiting for a clock edge.
